// File: rtl/muldiv_unit.sv
// Iterative M-extension unit: shift-add multiplier and restoring divider.
// It takes one operand pair at a time and gives a single-cycle done pulse with the result.
package muldiv_pkg;
   typedef enum logic [3:0] {
      OP_NOP, OP_ADD, OP_SUB, OP_AND,
      OP_MUL, OP_MULW, OP_DIV, OP_DIVW, OP_DIVU, OP_DIVUW,
      OP_MOD, OP_MODW, OP_MODU, OP_MODUW
   } decode_op_t;
endpackage

module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_i,
   input  decode_op_t       op,
   input  logic [XLEN-1:0]  srca,
   input  logic [XLEN-1:0]  srcb,
   input  logic             flush,
   output logic             ready_o,
   output logic             done_o,
   output logic [XLEN-1:0]  result
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t           state, state_d;
   logic [6:0]       cnt;
   logic [XLEN-1:0]  acc, opa, opb;
   logic             is_w, is_rem, qneg, rneg;

   logic             is_md, dec_mul, dec_w, dec_sgn, dec_rem, accept;
   logic signed [XLEN-1:0] a_ext, b_ext;
   logic [XLEN-1:0]  a_mag, b_mag, min_v, spec_res;
   logic             a_neg, b_neg, b_zero, ovf, special;
   logic [XLEN-1:0]  mul_acc_nx, rem_nx, quo_nx;
   logic [XLEN:0]    rem_sh, diff;
   logic             qbit;

   // Apply the recorded sign, then sign-extend the low word for W ops.
   function automatic logic [XLEN-1:0] fixup(input logic [XLEN-1:0] v,
                                             input logic neg, input logic w);
      logic [XLEN-1:0] t;
      t = neg ? -v : v;
      return w ? {{(XLEN-32){t[31]}}, t[31:0]} : t;
   endfunction

   always_comb begin
      is_md   = 1'b1;
      dec_mul = 1'b0;
      dec_w   = 1'b0;
      dec_sgn = 1'b0;
      dec_rem = 1'b0;
      case (op)
         OP_MUL:   dec_mul = 1'b1;
         OP_MULW:  begin dec_mul = 1'b1; dec_w = 1'b1; end
         OP_DIV:   dec_sgn = 1'b1;
         OP_DIVW:  begin dec_sgn = 1'b1; dec_w = 1'b1; end
         OP_DIVU:  ;
         OP_DIVUW: dec_w = 1'b1;
         OP_MOD:   begin dec_sgn = 1'b1; dec_rem = 1'b1; end
         OP_MODW:  begin dec_sgn = 1'b1; dec_rem = 1'b1; dec_w = 1'b1; end
         OP_MODU:  dec_rem = 1'b1;
         OP_MODUW: begin dec_rem = 1'b1; dec_w = 1'b1; end
         default:  is_md = 1'b0;
      endcase
   end

   assign accept = valid_i && (state == IDLE) && is_md && !flush;

   // W operands are sign-extended so that one signed path serves both widths.
   assign a_ext  = dec_w ? {{(XLEN-32){srca[31]}}, srca[31:0]} : srca;
   assign b_ext  = dec_w ? {{(XLEN-32){srcb[31]}}, srcb[31:0]} : srcb;
   assign a_neg  = dec_sgn && a_ext[XLEN-1];
   assign b_neg  = dec_sgn && b_ext[XLEN-1];
   assign a_mag  = a_neg ? -a_ext : a_ext;
   assign b_mag  = b_neg ? -b_ext : b_ext;
   assign min_v  = dec_w ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
   assign b_zero = dec_w ? (srcb[31:0] == 32'b0) : (srcb == '0);
   assign ovf    = dec_sgn && (a_ext == min_v) && (b_ext == '1);
   assign special = !dec_mul && (b_zero || ovf);

   always_comb begin
      spec_res = '0;
      if (b_zero)
         spec_res = dec_rem ? a_ext : '1;
      else if (ovf)
         spec_res = dec_rem ? '0 : a_ext;
   end

   assign mul_acc_nx = acc + (opb[0] ? opa : '0);
   assign rem_sh     = {acc, opa[XLEN-1]};
   assign diff       = rem_sh - {1'b0, opb};
   assign qbit       = !diff[XLEN];
   assign rem_nx     = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
   assign quo_nx     = {opa[XLEN-2:0], qbit};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      ready_o = 1'b0;
      done_o  = 1'b0;
      case (state)
         IDLE: begin
            ready_o = 1'b1;
            if (accept) state_d = special ? DONE : (dec_mul ? MUL : DIV);
         end
         MUL, DIV: begin
            if (flush)          state_d = IDLE;
            else if (cnt == 7'd1) state_d = DONE;
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         acc    <= '0;
         opa    <= '0;
         opb    <= '0;
         is_w   <= 1'b0;
         is_rem <= 1'b0;
         qneg   <= 1'b0;
         rneg   <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               is_w   <= dec_w;
               is_rem <= dec_rem;
               qneg   <= a_neg ^ b_neg;
               rneg   <= a_neg;
               cnt    <= dec_w ? 7'd32 : 7'd64;
               acc    <= '0;
               if (dec_mul) begin
                  opa <= a_ext;
                  opb <= b_ext;
               end else begin
                  // W dividends start in the top half so the same MSB-first walk applies.
                  opa <= dec_w ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
                  opb <= dec_w ? {{(XLEN-32){1'b0}}, b_mag[31:0]} : b_mag;
               end
               if (special) result <= spec_res;
            end
            MUL: begin
               acc <= mul_acc_nx;
               opa <= opa << 1;
               opb <= opb >> 1;
               cnt <= cnt - 7'd1;
               if (cnt == 7'd1 && !flush) result <= fixup(mul_acc_nx, 1'b0, is_w);
            end
            DIV: begin
               acc <= rem_nx;
               opa <= quo_nx;
               cnt <= cnt - 7'd1;
               if (cnt == 7'd1 && !flush)
                  result <= is_rem ? fixup(rem_nx, rneg, is_w) : fixup(quo_nx, qneg, is_w);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, completion timing, flush and reset.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic             clk;
   logic             reset;
   logic             valid_i;
   decode_op_t       op;
   logic [63:0]      srca, srcb;
   logic             flush;
   logic             ready_o, done_o;
   logic [63:0]      result;

   int total = 0;
   int bad   = 0;

   muldiv_unit #(.XLEN(64)) dut (
      .clk(clk), .reset(reset), .valid_i(valid_i), .op(op),
      .srca(srca), .srcb(srcb), .flush(flush),
      .ready_o(ready_o), .done_o(done_o), .result(result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Accept at edge 0; cycle c is the period following edge c-1.
   task automatic run_op(input string tag, input decode_op_t o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp_res, input int exp_cyc);
      int dcnt, dcyc, rbusy;
      logic [63:0] res;
      dcnt = 0; dcyc = 0; rbusy = 0; res = '0;
      @(negedge clk);
      valid_i = 1'b1; op = o; srca = a; srcb = b;
      @(posedge clk);
      #1 valid_i = 1'b0; op = OP_NOP;
      for (int c = 1; c <= exp_cyc + 1; c++) begin
         @(negedge clk);
         if (done_o) begin dcnt++; dcyc = c; res = result; end
         if (c <= exp_cyc && ready_o) rbusy++;
         if (c == exp_cyc + 1) chk({tag, " ready_after"}, 64'(ready_o), 64'd1);
      end
      chk({tag, " done_cyc"}, 64'(dcyc), 64'(exp_cyc));
      chk({tag, " done_cnt"}, 64'(dcnt), 64'd1);
      chk({tag, " busy_ready"}, 64'(rbusy), 64'd0);
      chk({tag, " result"}, res, exp_res);
   endtask

   initial begin
      int dseen;
      reset = 1'b1; valid_i = 1'b0; op = OP_NOP; srca = '0; srcb = '0; flush = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst ready", 64'(ready_o), 64'd1);
      chk("rst done", 64'(done_o), 64'd0);
      chk("rst result", result, 64'd0);
      reset = 1'b0;

      run_op("mul",    OP_MUL,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
      run_op("div",    OP_DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
      run_op("mod",    OP_MOD,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      run_op("divu",   OP_DIVU, 64'd100, 64'd7, 64'd14, 65);
      run_op("modu",   OP_MODU, 64'd100, 64'd7, 64'd2, 65);
      run_op("divu0",  OP_DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      run_op("modu0",  OP_MODU, 64'd5, 64'd0, 64'd5, 1);
      run_op("divovf", OP_DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h8000_0000_0000_0000, 1);
      run_op("modovf", OP_MOD,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
      run_op("mulw",   OP_MULW, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
      run_op("divuw",  OP_DIVUW, 64'hFFFF_FFFF_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 33);
      run_op("modw",   OP_MODW, 64'h1_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
      run_op("divw",   OP_DIVW, 64'h0000_0000_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 33);

      // Flush in IDLE blocks acceptance.
      @(negedge clk);
      valid_i = 1'b1; op = OP_MUL; srca = 64'd2; srcb = 64'd2; flush = 1'b1;
      @(posedge clk);
      #1 valid_i = 1'b0; flush = 1'b0; op = OP_NOP;
      @(negedge clk);
      chk("idleflush ready", 64'(ready_o), 64'd1);

      // Flush mid-DIV, then a fresh MUL from cycle 11.
      @(negedge clk);
      valid_i = 1'b1; op = OP_DIV; srca = 64'd100; srcb = 64'd7;
      @(posedge clk);
      #1 valid_i = 1'b0; op = OP_NOP;
      repeat (10) @(negedge clk);
      chk("flush busy", 64'(ready_o), 64'd0);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      chk("flush ready", 64'(ready_o), 64'd1);
      chk("flush done", 64'(done_o), 64'd0);
      run_op("mul_after", OP_MUL, 64'd3, 64'd4, 64'd12, 65);

      // Asynchronous reset in the middle of cycle 20 of a DIV.
      @(negedge clk);
      valid_i = 1'b1; op = OP_DIV; srca = 64'd100; srcb = 64'd7;
      @(posedge clk);
      #1 valid_i = 1'b0; op = OP_NOP;
      repeat (20) @(negedge clk);
      chk("arst busy", 64'(ready_o), 64'd0);
      #2 reset = 1'b1;
      #1;
      chk("arst ready", 64'(ready_o), 64'd1);
      chk("arst done", 64'(done_o), 64'd0);
      chk("arst result", result, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // A non-muldiv op is ignored.
      @(negedge clk);
      valid_i = 1'b1; op = OP_ADD; srca = 64'd1; srcb = 64'd1;
      @(posedge clk);
      #1 valid_i = 1'b0; op = OP_NOP;
      dseen = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (done_o) dseen++;
         if (!ready_o) dseen++;
      end
      chk("add ignored", 64'(dseen), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
